// File: rtl/mul_share_pkg.sv
// Shared types and widths for the shared 8x8 multiplier arbiter.
package mul_share_pkg;

  localparam int OPW   = 8;
  localparam int PRODW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between multiply clients (master) and the arbiter (slave).
interface mul_share_arbiter_if #(
  parameter int NREQ = 4
) ();
  import mul_share_pkg::*;

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [PRODW-1:0]    rsp_data;
  logic [IDW-1:0]      rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/a16_bit_mul.sv
// Unsigned 8x8 -> 16 ripple array multiplier (combinational, multicycle at use site).
module a16_bit_mul (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  always_comb begin
    p_o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b_i[i]) p_o = p_o + (16'(a_i) << i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after ptr+1 (mod NREQ).
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_any_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(ptr_i) + k) % NREQ);
      if (!gnt_any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        gnt_any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one a16_bit_mul among NREQ requesters, with a
// programmable settle window before the product is captured.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mul_share_arbiter_if.slave  bus,
  output logic [15:0]         ops_done
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OPW-1:0]   op_a_q, op_a_d;
  logic [OPW-1:0]   op_b_q, op_b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [PRODW-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [15:0]      ops_done_q, ops_done_d;

  logic [NREQ-1:0]  gnt_oh;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [PRODW-1:0] product;
  int unsigned      sel;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  a16_bit_mul u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (product)
  );

  // Gated with rst_n so nothing looks accepted while the block is held in reset.
  assign bus.req_ready = (state_q == ST_IDLE && rst_n) ? gnt_oh : '0;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign ops_done      = ops_done_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    ops_done_d = ops_done_q;
    sel        = 32'(gnt_idx) * OPW;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          op_a_d  = bus.req_a[sel +: OPW];
          op_b_d  = bus.req_b[sel +: OPW];
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETTLE - 1)) begin
          rsp_data_d = product;
          rsp_id_d   = id_q;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      ops_done_q <= ops_done_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench: NREQ=4/SETTLE=2 instance plus a NREQ=2/SETTLE=1 instance.
module tb_mul_share_arbiter;
  import mul_share_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ops0, ops1;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          exp_ops  = 0;

  mul_share_arbiter_if #(.NREQ(4)) bus0 ();
  mul_share_arbiter_if #(.NREQ(2)) bus1 ();

  mul_share_arbiter #(.NREQ(4), .SETTLE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .ops_done(ops0)
  );
  mul_share_arbiter #(.NREQ(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .ops_done(ops1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; returns cycles until rsp_valid.
  task automatic wait_rsp0(output int lat);
    lat = 0;
    while (!bus0.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op0(input int idx, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] data, output logic [1:0] id, output int lat);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    bus0.req_a[idx*8 +: 8] = a;
    bus0.req_b[idx*8 +: 8] = b;
    bus0.req_valid = onehot;
    #1 check_eq("req_ready_grant", 32'(bus0.req_ready), 32'(onehot));
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = '0;
    check_eq("calc_ready_low", 32'(bus0.req_ready), 32'd0);
    wait_rsp0(lat);
    data = bus0.rsp_data;
    id   = bus0.rsp_id;
  endtask

  logic [15:0] d;
  logic [1:0]  id;
  int          lat;
  int          stamp_prev;
  logic [1:0]  rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [15:0] rr_prod  [5] = '{16'h0030, 16'h0033, 16'h0036, 16'h0039, 16'h0030};

  initial begin
    bus0.req_valid = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.rsp_ready = 1'b0;
    bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b0;
    stamp_prev = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check_eq("rst_rsp_data",  32'(bus0.rsp_data),  32'd0);
    check_eq("rst_rsp_id",    32'(bus0.rsp_id),    32'd0);
    check_eq("rst_req_ready", 32'(bus0.req_ready), 32'd0);
    check_eq("rst_ops_done",  32'(ops0),           32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, consumer not ready at first
    do_op0(1, 8'h0C, 8'h0D, d, id, lat);
    check_eq("single_latency", 32'(lat), 32'd2);
    check_eq("single_data",    32'(d),   32'h009C);
    check_eq("single_id",      32'(id),  32'd1);
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    exp_ops++;
    check_eq("single_ops_done", 32'(ops0), 32'(exp_ops));
    check_eq("single_rsp_drop", 32'(bus0.rsp_valid), 32'd0);

    // Round robin from reset: all four held valid
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    for (int i = 0; i < 4; i++) begin
      bus0.req_a[i*8 +: 8] = 8'h10 + 8'(i);
      bus0.req_b[i*8 +: 8] = 8'h03;
    end
    bus0.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      lat = 0;
      while (!bus0.rsp_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check_eq("rr_id",   32'(bus0.rsp_id),   32'(rr_order[k]));
      check_eq("rr_data", 32'(bus0.rsp_data), 32'(rr_prod[k]));
      if (k > 0) check_eq("rr_interval", 32'(cyc - stamp_prev), 32'd4);
      stamp_prev = cyc;
      exp_ops++;
      @(negedge clk);
    end
    bus0.req_valid = '0;
    check_eq("rr_ops_done", 32'(ops0), 32'(exp_ops));

    // Corner operands
    do_op0(2, 8'hFF, 8'hFF, d, id, lat);
    check_eq("ff_ff_data", 32'(d), 32'hFE01);
    check_eq("ff_ff_id",   32'(id), 32'd2);
    @(negedge clk); exp_ops++;
    do_op0(3, 8'h00, 8'hA5, d, id, lat);
    check_eq("zero_data", 32'(d), 32'h0000);
    check_eq("zero_id",   32'(id), 32'd3);
    @(negedge clk); exp_ops++;
    do_op0(0, 8'h80, 8'h02, d, id, lat);
    check_eq("x80_data",    32'(d), 32'h0100);
    check_eq("x80_latency", 32'(lat), 32'd2);
    @(negedge clk); exp_ops++;
    check_eq("corner_ops_done", 32'(ops0), 32'(exp_ops));

    // Backpressure: 10 stalled cycles with another request pending
    bus0.rsp_ready = 1'b0;
    do_op0(1, 8'h07, 8'h09, d, id, lat);
    bus0.req_a[2*8 +: 8] = 8'h44;
    bus0.req_b[2*8 +: 8] = 8'h44;
    bus0.req_valid = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      #1 check_eq("bp_stall", {bus0.rsp_valid, bus0.rsp_data, bus0.req_ready},
                  {1'b1, 16'h003F, 4'b0000});
      @(negedge clk);
    end
    bus0.rsp_ready = 1'b1;
    bus0.req_valid = '0;
    @(negedge clk);
    exp_ops++;
    check_eq("bp_ops_done", 32'(ops0), 32'(exp_ops));
    check_eq("bp_rsp_drop", 32'(bus0.rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("bp_skip_idle", {30'd0, bus0.rsp_valid, |bus0.req_ready}, 32'd0);

    // Reset one cycle into CALC
    bus0.req_a[3*8 +: 8] = 8'h55;
    bus0.req_b[3*8 +: 8] = 8'h02;
    bus0.req_valid = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus0.req_a[i*8 +: 8] = 8'h20 + 8'(i);
      bus0.req_b[i*8 +: 8] = 8'h02;
    end
    bus0.req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check_eq("arst_rsp_data",  32'(bus0.rsp_data),  32'd0);
    check_eq("arst_rsp_id",    32'(bus0.rsp_id),    32'd0);
    check_eq("arst_req_ready", 32'(bus0.req_ready), 32'd0);
    check_eq("arst_ops_done",  32'(ops0),           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    lat = 0;
    while (!bus0.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("arst_first_id",   32'(bus0.rsp_id),   32'd0);
    check_eq("arst_first_data", 32'(bus0.rsp_data), 32'h0040);
    @(negedge clk);
    bus0.req_valid = '0;
    exp_ops++;
    check_eq("arst_ops_done_after", 32'(ops0), 32'(exp_ops));

    // SETTLE=1 instance: latency and counter wrap
    bus1.req_a[15:8] = 8'h0C;
    bus1.req_b[15:8] = 8'h0D;
    bus1.req_valid = 2'b10;
    #1 check_eq("s1_req_ready", 32'(bus1.req_ready), 32'b10);
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = '0;
    lat = 0;
    while (!bus1.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("s1_latency", 32'(lat), 32'd1);
    check_eq("s1_data",    32'(bus1.rsp_data), 32'h009C);
    check_eq("s1_id",      32'(bus1.rsp_id),   32'd1);
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("s1_ops_done", 32'(ops1), 32'd1);

    force dut1.ops_done_q = 16'hFFFF;
    #1 release dut1.ops_done_q;
    bus1.req_a[7:0] = 8'h80;
    bus1.req_b[7:0] = 8'h02;
    bus1.req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = '0;
    lat = 0;
    while (!bus1.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("wrap_data", 32'(bus1.rsp_data), 32'h0100);
    @(negedge clk);
    check_eq("wrap_ops_done", 32'(ops1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Shares one combinational 8x8 array multiplier (`a16_bit_mul`) among NREQ requesters. Arbitration is round-robin, with a valid/ready handshake on each request port and on the single response port. Operands are registered. The product is sampled only after a programmable multicycle settle window, because the ripple array is too slow to close in one cycle. The block sits between the multiply clients and the shared multiplier instance, which it owns.

## Interface
- NREQ, 4, number of requesters (2..8)
- SETTLE, 2, cycles the multiplier output settles before capture (≥1)
- IDW, $clog2(NREQ), requester-ID width (derived, not overridable)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*8  packed operand A, requester i at [8i+7:8i]
- req_b  in  NREQ*8  packed operand B, same packing
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts product
- rsp_data  out  16  unsigned product A*B
- rsp_id  out  IDW  index of the requester that issued the operation
- ops_done  out  16  completed-response count, wraps at 0xFFFF→0

## Operation
- FSM has three states: IDLE, CALC, RESP.
- IDLE:
  - Grant g is the first asserted req_valid at or after index ptr+1 (mod NREQ).
  - req_ready[g]=1 combinationally in IDLE only.
  - On the handshake (req_valid[g]&req_ready[g]): latch op_a, op_b and id=g, set ptr=g, cnt=0, go to CALC.
  - With no req_valid asserted, stay in IDLE.
- CALC:
  - op_a and op_b drive the multiplier.
  - cnt increments each cycle.
  - When cnt==SETTLE-1: rsp_data←product, rsp_id←id, go to RESP.
  - req_ready is all zero.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - On rsp_valid&rsp_ready: ops_done++, go to IDLE.
  - While rsp_ready=0 the block stalls indefinitely; new requests are not accepted.
- Arithmetic is unsigned 8x8→16 with no truncation. 0xFF*0xFF=0xFE01.
- Requesters must hold valid and operands until accepted. A requester that drops valid before its grant is simply skipped.
- Reset values:
  - state=IDLE, ptr=NREQ-1 (requester 0 wins first).
  - op_a=op_b=0, rsp_data=0, rsp_id=0, rsp_valid=0, req_ready=0, ops_done=0, cnt=0.
- Reset mid-CALC or mid-RESP aborts the operation. The result is discarded and not counted.

## Timing
- Accept at edge E0 → rsp_valid high after edge E(SETTLE). For SETTLE=2, that is 2 cycles.
- Response handshake at edge R → IDLE in the next cycle. The earliest next accept is edge R+1.
- Minimum initiation interval is SETTLE+2 cycles.
- req_ready depends combinationally on req_valid and ptr. There is no other comb path from inputs to outputs.
- Operands are stable from E0 through capture. The multiplier output is therefore a declared multicycle path of SETTLE cycles.

## Structure
- Package mul_share_pkg:
  - state enum {IDLE, CALC, RESP}
  - localparam OPW=8, PRODW=16
  - function for the ID width
- Sub-module rr_arbiter: takes NREQ request bits and ptr; returns a one-hot grant and its encoded index. It is purely combinational and reusable.
- One a16_bit_mul instance, fed by op_a and op_b.

## Test plan
- Single request: req 1 with A=0x0C, B=0x0D, SETTLE=2 → rsp_data=0x009C, rsp_id=1, rsp_valid rises 2 cycles after accept, ops_done=1.
- All four requests held valid continuously, rsp_ready=1 → grant order 0,1,2,3,0. Each response is SETTLE+2 cycles apart.
- Corner operands: 0xFF*0xFF → 0xFE01; 0x00*0xA5 → 0x0000; 0x80*0x02 → 0x0100.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_valid and rsp_data stable throughout, req_ready=0. Then rsp_ready=1 → one response, ops_done increments by 1.
- Reset mid-operation: assert rst_n=0 one cycle into CALC → all outputs return to reset values immediately (asynchronous). After release, requester 0 is granted first and the aborted result is never emitted.
- Counter wrap: preload to 65535 completions → the next response makes ops_done=0. SETTLE=1 build: rsp_valid appears 1 cycle after accept.
